hazard_stall_unit: RTL and testbench

//  Stall/flush controller for the 5-stage RISC-V pipeline; the decode-side counterpart of the forwarding unit.

---
 rtl/hazard_stall_unit.sv | 75 +++++++
 tb/tb_hazard_stall_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, branch flush and data-memory freeze/timeout control for the 5-stage pipeline.
// Optional STALL_PERF_EN macro enables the saturating StallCycles counter.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic [4:0]  RD_E,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [31:0] StallCycles
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10} state_t;
    localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);
    state_t state;
    logic [TO_W-1:0] wait_cnt;
    logic lw_stall, mem_stall;
    always_comb begin
        lw_stall  = LoadE && RD_E != 5'd0 && (RD_E == Rs1_D || RD_E == Rs2_D);
        mem_stall = state == HALT || (MemReqM && !MemReadyM);
        StallF    = !rst && (lw_stall || mem_stall);
        StallD    = StallF;
        StallE    = !rst && mem_stall;
        StallM    = StallE;
        FlushW    = StallE;
        FlushE    = !rst && (lw_stall || PCSrcE) && !mem_stall;
        FlushD    = !rst && PCSrcE && !mem_stall;
        MemErr    = !rst && state == HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (MemReqM && !MemReadyM) begin
                    state    <= MEM_TIMEOUT == 1 ? HALT : MEM_WAIT;
                    wait_cnt <= TO_W'(1);
                end
                MEM_WAIT: if (MemReadyM) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (MEM_TIMEOUT != 0 && wait_cnt == LAST) begin
                    state <= HALT;
                end else begin
                    wait_cnt <= wait_cnt + TO_W'(1);
                end
                default: state <= HALT;
            endcase
        end
    end
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (StallF && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
    assign StallCycles = stall_cnt;
`else
    assign StallCycles = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table-driven vectors plus multi-cycle sequences, checked through an expectation queue.
module tb_hazard_stall_unit;
    logic clk = 0, rst;
    logic [4:0] Rs1_D, Rs2_D, RD_E;
    logic LoadE, PCSrcE, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [31:0] StallCycles;
    int compared = 0, mismatched = 0;
    logic [31:0] sc_exp = 0;

    // o = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemErr}
    typedef struct {
        string name;
        logic r;
        logic [4:0] rs1, rs2, rd;
        logic ld, pc, req, rdy;
        logic [7:0] o;
    } vec_t;
    typedef struct {
        string name;
        logic [7:0] o;
        logic [31:0] sc;
    } exp_t;
    exp_t sb[$];

    hazard_stall_unit #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    task automatic step(input vec_t v);
        exp_t e;
        logic [7:0] act;
        @(negedge clk);
        rst = v.r; Rs1_D = v.rs1; Rs2_D = v.rs2; RD_E = v.rd;
        LoadE = v.ld; PCSrcE = v.pc; MemReqM = v.req; MemReadyM = v.rdy;
        sb.push_back('{v.name, v.o, sc_exp});
        #2;
        e = sb.pop_front();
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};
        compared++;
        if (act !== e.o) begin
            mismatched++;
            $display("FAIL %s: outputs got %b expected %b", e.name, act, e.o);
        end
        compared++;
        if (StallCycles !== e.sc) begin
            mismatched++;
            $display("FAIL %s: StallCycles got %0d expected %0d", e.name, StallCycles, e.sc);
        end
`ifdef STALL_PERF_EN
        sc_exp = v.r ? 32'd0 : sc_exp + {31'd0, v.o[7]};
`endif
    endtask

    vec_t tbl[$];
    initial begin
        tbl = '{
            '{"reset_override", 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 8'b0000_0000},
            '{"reset_hold",     1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000},
            '{"lw_rs2",         0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 8'b1100_0100},
            '{"lw_x0",          0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 8'b0000_0000},
            '{"branch",         0, 5'd3, 5'd4, 5'd3, 0, 1, 0, 0, 8'b0000_1100},
            '{"lw_rs1",         0, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 8'b1100_0100},
            '{"no_load",        0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 8'b0000_0000},
            '{"lw_nomatch",     0, 5'd1, 5'd2, 5'd7, 1, 0, 0, 0, 8'b0000_0000},
            '{"lw_and_branch",  0, 5'd9, 5'd2, 5'd9, 1, 1, 0, 0, 8'b1100_1100},
            '{"mem_ready_now",  0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1, 8'b0000_0000},
            '{"idle",           0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000},
            // three not-ready cycles with pending hazards, then release
            '{"wait1",          0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0, 8'b1111_0010},
            '{"wait2",          0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0, 8'b1111_0010},
            '{"wait3",          0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0, 8'b1111_0010},
            '{"release",        0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1, 8'b0000_0000},
            '{"after_release",  0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 8'b1100_1100},
            // timeout: HALT after the fourth not-ready cycle
            '{"to_wait1",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"to_wait2",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"to_wait3",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"to_wait4",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"halt_ready",     0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 8'b1111_0011},
            '{"halt_hazards",   0, 5'd4, 5'd0, 5'd4, 1, 1, 0, 1, 8'b1111_0011},
            '{"halt_rst",       1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000},
            '{"halt_cleared",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000},
            // reset in the middle of a wait
            '{"mw_wait1",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"mw_wait2",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"mw_rst",         1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b0000_0000},
            '{"mw_run",         0, 5'd2, 5'd0, 5'd0, 0, 1, 0, 0, 8'b0000_1100},
            '{"mw_new1",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"mw_new2",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"mw_new3",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 8'b1111_0010},
            '{"mw_new_ready",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 8'b0000_0000},
            '{"mw_end",         0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'b0000_0000}
        };
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
